// File: rtl/register_read_stage.sv
// register_read_stage: register-read pipeline stage feeding execute.
// Owns the 16x32 architectural register file, resolves operands and
// detects RAW hazards. Instructions leave through the registered rr_* outputs.
// Optional feature macro RR_OPFWD_EN:
//   defined   -> operands are forwarded from the execute and memory stages.
//   undefined -> there is no exec/mem forwarding. A pending-write scoreboard
//                stalls dependent instructions until their writeback.
module register_read_stage #(
  parameter int NREGS = 16,
  parameter int XLEN  = 32,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            dec_valid,
  output logic            rr_ready,
  input  logic [XLEN-1:0] dec_pc,
  input  logic [5:0]      dec_op,
  input  logic [7:0]      dec_altop,
  input  logic [IW-1:0]   dec_rd,
  input  logic [IW-1:0]   dec_rs,
  input  logic [IW-1:0]   dec_rt,
  input  logic            dec_rs_used,
  input  logic            dec_rt_used,
  input  logic [XLEN-1:0] dec_imm32,
  input  logic            exec_stall,
  input  logic            exec_flush,
  input  logic [IW-1:0]   exec_of_reg,
  input  logic [XLEN-1:0] exec_of_val,
  input  logic            exec_of_load,
  input  logic [IW-1:0]   mem_of_reg,
  input  logic [XLEN-1:0] mem_of_val,
  input  logic            wb_we,
  input  logic [IW-1:0]   wb_reg,
  input  logic [XLEN-1:0] wb_val,
  output logic [XLEN-1:0] rr_pc,
  output logic [5:0]      rr_op,
  output logic [7:0]      rr_altop,
  output logic [IW-1:0]   rr_rd,
  output logic [XLEN-1:0] rr_rs_val,
  output logic [XLEN-1:0] rr_rt_val,
  output logic [XLEN-1:0] rr_imm32
);

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            load_use;
  logic            hazard;
  logic            latch_dec;

  // Load in execute whose result a used source needs: one bubble until it reaches mem
  assign load_use = dec_valid && exec_of_load && (exec_of_reg != '0) &&
                    ((dec_rs_used && (dec_rs == exec_of_reg)) ||
                     (dec_rt_used && (dec_rt == exec_of_reg)));

`ifdef RR_OPFWD_EN
  assign hazard = load_use;
`else
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;
  logic             rs_wait;
  logic             rt_wait;
  logic             unused_fwd_inputs;

  // A same-cycle writeback of the awaited register satisfies the source via write-through
  assign rs_wait = dec_rs_used && (dec_rs != '0) && pending[dec_rs] &&
                   !(wb_we && (wb_reg == dec_rs));
  assign rt_wait = dec_rt_used && (dec_rt != '0) && pending[dec_rt] &&
                   !(wb_we && (wb_reg == dec_rt));
  assign hazard  = load_use || (dec_valid && (rs_wait || rt_wait));
  assign unused_fwd_inputs = ^{exec_of_val, mem_of_reg, mem_of_val};

  // Clear on writeback first, so a newly latched writer of the same register stays pending
  always_comb begin
    pending_next = pending;
    if (wb_we) pending_next[wb_reg] = 1'b0;
    if (latch_dec && (dec_rd != '0)) pending_next[dec_rd] = 1'b1;
  end

  // Scoreboard register; flushes leave it alone since older instructions still retire
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) pending <= '0;
    else            pending <= pending_next;
  end
`endif

  assign latch_dec = dec_valid && !exec_stall && !exec_flush && !hazard;
  assign rr_ready  = i_reset_n && !exec_stall && !hazard;

  // rs operand: exec forward, then mem forward, then write-through, then regfile; r0 is zero
  always_comb begin
    rs_val = regs[dec_rs];
    if (wb_we && (wb_reg == dec_rs)) rs_val = wb_val;
`ifdef RR_OPFWD_EN
    if (mem_of_reg == dec_rs) rs_val = mem_of_val;
    if (exec_of_reg == dec_rs) rs_val = exec_of_val;
`endif
    if (dec_rs == '0) rs_val = '0;
  end

  // rt operand: same priority as rs
  always_comb begin
    rt_val = regs[dec_rt];
    if (wb_we && (wb_reg == dec_rt)) rt_val = wb_val;
`ifdef RR_OPFWD_EN
    if (mem_of_reg == dec_rt) rt_val = mem_of_val;
    if (exec_of_reg == dec_rt) rt_val = exec_of_val;
`endif
    if (dec_rt == '0) rt_val = '0;
  end

  // Register file write port; writebacks land even while execute stalls or flushes
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && (wb_reg != '0)) begin
      regs[wb_reg] <= wb_val;
    end
  end

  // Pipeline register into execute: hold on stall, else latch or insert a bubble
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_pc     <= '0;
      rr_op     <= '0;
      rr_altop  <= '0;
      rr_rd     <= '0;
      rr_rs_val <= '0;
      rr_rt_val <= '0;
      rr_imm32  <= '0;
    end else if (!exec_stall) begin
      if (latch_dec) begin
        rr_pc     <= dec_pc;
        rr_op     <= dec_op;
        rr_altop  <= dec_altop;
        rr_rd     <= dec_rd;
        rr_rs_val <= rs_val;
        rr_rt_val <= rt_val;
        rr_imm32  <= dec_imm32;
      end else begin
        rr_pc     <= '0;
        rr_op     <= '0;
        rr_altop  <= '0;
        rr_rd     <= '0;
        rr_rs_val <= '0;
        rr_rt_val <= '0;
        rr_imm32  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_register_read_stage.sv
// tb_register_read_stage: directed and random stimulus for register_read_stage.
// It checks against a reference model of the stage's rules that is kept in this file.
// The model follows RR_OPFWD_EN the same way the design does.
module tb_register_read_stage;

  logic        i_clk;
  logic        i_reset_n;
  logic        dec_valid;
  logic        rr_ready;
  logic [31:0] dec_pc;
  logic [5:0]  dec_op;
  logic [7:0]  dec_altop;
  logic [3:0]  dec_rd, dec_rs, dec_rt;
  logic        dec_rs_used, dec_rt_used;
  logic [31:0] dec_imm32;
  logic        exec_stall, exec_flush;
  logic [3:0]  exec_of_reg;
  logic [31:0] exec_of_val;
  logic        exec_of_load;
  logic [3:0]  mem_of_reg;
  logic [31:0] mem_of_val;
  logic        wb_we;
  logic [3:0]  wb_reg;
  logic [31:0] wb_val;
  logic [31:0] rr_pc;
  logic [5:0]  rr_op;
  logic [7:0]  rr_altop;
  logic [3:0]  rr_rd;
  logic [31:0] rr_rs_val, rr_rt_val, rr_imm32;

  int errors = 0;
  int checks = 0;

  // Reference model state: architectural registers, pending writes, expected outputs
  logic [31:0] mReg [16];
  bit          mPend [16];
  logic [31:0] ePc, eRs, eRt, eImm;
  logic [5:0]  eOp;
  logic [7:0]  eAlt;
  logic [3:0]  eRd;

  register_read_stage dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .dec_valid(dec_valid), .rr_ready(rr_ready),
    .dec_pc(dec_pc), .dec_op(dec_op), .dec_altop(dec_altop), .dec_rd(dec_rd),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used),
    .dec_imm32(dec_imm32), .exec_stall(exec_stall), .exec_flush(exec_flush),
    .exec_of_reg(exec_of_reg), .exec_of_val(exec_of_val), .exec_of_load(exec_of_load),
    .mem_of_reg(mem_of_reg), .mem_of_val(mem_of_val), .wb_we(wb_we), .wb_reg(wb_reg),
    .wb_val(wb_val), .rr_pc(rr_pc), .rr_op(rr_op), .rr_altop(rr_altop), .rr_rd(rr_rd),
    .rr_rs_val(rr_rs_val), .rr_rt_val(rr_rt_val), .rr_imm32(rr_imm32)
  );

  // Free-running clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Value an instruction would see for a source register given the current inputs
  function automatic logic [31:0] mRead(input logic [3:0] idx);
    if (idx == 4'd0) return 32'd0;
`ifdef RR_OPFWD_EN
    if (exec_of_reg == idx) return exec_of_val;
    if (mem_of_reg == idx) return mem_of_val;
`endif
    if (wb_we && wb_reg == idx) return wb_val;
    return mReg[idx];
  endfunction

  function automatic bit mBlocked(input logic [3:0] idx, input logic used);
`ifdef RR_OPFWD_EN
    return 1'b0;
`else
    return used && idx != 4'd0 && mPend[idx] && !(wb_we && wb_reg == idx);
`endif
  endfunction

  function automatic bit mHazard();
    bit loadUse;
    loadUse = exec_of_load && exec_of_reg != 4'd0 &&
              ((dec_rs_used && dec_rs == exec_of_reg) || (dec_rt_used && dec_rt == exec_of_reg));
    return dec_valid && (loadUse || mBlocked(dec_rs, dec_rs_used) || mBlocked(dec_rt, dec_rt_used));
  endfunction

  task automatic mReset();
    for (int i = 0; i < 16; i++) begin
      mReg[i]  = 32'd0;
      mPend[i] = 1'b0;
    end
    ePc = 0; eRs = 0; eRt = 0; eImm = 0; eOp = 0; eAlt = 0; eRd = 0;
  endtask

  // Advance the model across one clock edge using the inputs now applied
  task automatic mEdge();
    logic [31:0] a, b;
    bit hz, take;
    a = mRead(dec_rs);
    b = mRead(dec_rt);
    hz = mHazard();
    take = dec_valid && !exec_stall && !exec_flush && !hz;
    if (!exec_stall) begin
      if (take) begin
        ePc = dec_pc; eOp = dec_op; eAlt = dec_altop; eRd = dec_rd;
        eRs = a; eRt = b; eImm = dec_imm32;
      end else begin
        ePc = 0; eOp = 0; eAlt = 0; eRd = 0; eRs = 0; eRt = 0; eImm = 0;
      end
    end
    if (wb_we) mPend[wb_reg] = 1'b0;
    if (take && dec_rd != 4'd0) mPend[dec_rd] = 1'b1;
    if (wb_we && wb_reg != 4'd0) mReg[wb_reg] = wb_val;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_pc"}, rr_pc, ePc);
    checkOutput({tag, "_op"}, 32'(rr_op), 32'(eOp));
    checkOutput({tag, "_altop"}, 32'(rr_altop), 32'(eAlt));
    checkOutput({tag, "_rd"}, 32'(rr_rd), 32'(eRd));
    checkOutput({tag, "_rsval"}, rr_rs_val, eRs);
    checkOutput({tag, "_rtval"}, rr_rt_val, eRt);
    checkOutput({tag, "_imm"}, rr_imm32, eImm);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [5:0] op,
                               input logic [7:0] alt, input logic [3:0] rd, input logic [3:0] rs,
                               input logic [3:0] rt, input logic rsU, input logic rtU,
                               input logic [31:0] imm);
    dec_valid = v; dec_pc = pc; dec_op = op; dec_altop = alt; dec_rd = rd;
    dec_rs = rs; dec_rt = rt; dec_rs_used = rsU; dec_rt_used = rtU; dec_imm32 = imm;
  endtask

  task automatic applySide(input logic stall, input logic flush, input logic [3:0] eReg,
                           input logic [31:0] eVal, input logic eLoad, input logic [3:0] mRg,
                           input logic [31:0] mVal, input logic we, input logic [3:0] wReg,
                           input logic [31:0] wVal);
    exec_stall = stall; exec_flush = flush; exec_of_reg = eReg; exec_of_val = eVal;
    exec_of_load = eLoad; mem_of_reg = mRg; mem_of_val = mVal;
    wb_we = we; wb_reg = wReg; wb_val = wVal;
  endtask

  // One cycle: check combinational ready, step the model, clock, check registered outputs
  task automatic stepCycle(input string tag);
    #1;
    checkOutput({tag, "_ready"}, 32'(rr_ready), 32'(!exec_stall && !mHazard()));
    mEdge();
    @(posedge i_clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    i_reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applySide(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mReset();
    repeat (2) @(posedge i_clk);
    #1;
    checkAll("reset");
    checkOutput("reset_ready", 32'(rr_ready), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    mEdge();
    @(posedge i_clk);
    #1;

    // r1 reads zero after reset
    applyStimulus(1, 32'h100, 6'd1, 8'd0, 4'd0, 4'd1, 4'd0, 1, 0, 32'd0);
    stepCycle("r1zero");
    checkOutput("r1zero_const", rr_rs_val, 32'd0);

    // Stall wins over flush; the writeback still lands
    applyStimulus(1, 32'h104, 6'd5, 8'h3c, 4'd0, 4'd2, 4'd3, 1, 1, 32'hffff_fff0);
    stepCycle("latch");
    applyStimulus(1, 32'h108, 6'd7, 8'h11, 4'd5, 4'd1, 4'd1, 1, 1, 32'h8);
    applySide(1, 1, 0, 0, 0, 0, 0, 1, 4'd4, 32'd7);
    stepCycle("stallflush");
    checkOutput("stallflush_op", 32'(rr_op), 32'd5);
    applySide(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h10c, 6'd2, 8'd0, 4'd0, 4'd4, 4'd0, 1, 0, 32'd0);
    stepCycle("readr4");
    checkOutput("readr4_const", rr_rs_val, 32'd7);

    // A flush drops the decoded instruction
    applyStimulus(1, 32'h110, 6'd9, 8'h22, 4'd6, 4'd1, 4'd2, 1, 1, 32'h5);
    applySide(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("flush");
    checkOutput("flush_op", 32'(rr_op), 32'd0);
    checkOutput("flush_rd", 32'(rr_rd), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applySide(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("postflush");
    checkOutput("postflush_op", 32'(rr_op), 32'd0);

    // Load-use: one bubble, then the value comes through mem
    applyStimulus(1, 32'h120, 6'd3, 8'd0, 4'd7, 4'd3, 4'd0, 1, 0, 32'd0);
    applySide(0, 0, 4'd3, 32'hdead_beef, 1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("loaduse_ready_const", 32'(rr_ready), 32'd0);
    stepCycle("loaduse");
    checkOutput("loaduse_bubble", 32'(rr_op), 32'd0);
    applySide(0, 0, 0, 0, 0, 4'd3, 32'h1234, 0, 0, 0);
    stepCycle("loadmem");
    checkOutput("loadmem_op", 32'(rr_op), 32'd3);
`ifdef RR_OPFWD_EN
    checkOutput("loadmem_fwd", rr_rs_val, 32'h1234);

    // Back-to-back dependency forwarded from execute
    applyStimulus(1, 32'h200, 6'd8, 8'd0, 4'd1, 4'd0, 4'd0, 1, 0, 32'd5);
    applySide(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("addi");
    applyStimulus(1, 32'h204, 6'd1, 8'd0, 4'd2, 4'd1, 4'd1, 1, 1, 32'd0);
    applySide(0, 0, 4'd1, 32'd5, 0, 0, 0, 0, 0, 0);
    stepCycle("execfwd");
    checkOutput("execfwd_rs", rr_rs_val, 32'd5);
    checkOutput("execfwd_rt", rr_rt_val, 32'd5);
    checkOutput("execfwd_op", 32'(rr_op), 32'd1);
`else
    // Dependent instruction waits for writeback, then takes the write-through value
    applyStimulus(1, 32'h200, 6'd8, 8'd0, 4'd1, 4'd0, 4'd0, 1, 0, 32'd5);
    applySide(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle("addi");
    applyStimulus(1, 32'h204, 6'd1, 8'd0, 4'd2, 4'd1, 4'd1, 1, 1, 32'd0);
    stepCycle("depwait0");
    checkOutput("depwait0_op", 32'(rr_op), 32'd0);
    stepCycle("depwait1");
    checkOutput("depwait1_op", 32'(rr_op), 32'd0);
    applySide(0, 0, 0, 0, 0, 0, 0, 1, 4'd1, 32'h55);
    stepCycle("depwb");
    checkOutput("depwb_rs", rr_rs_val, 32'h55);
    checkOutput("depwb_rt", rr_rt_val, 32'h55);
    checkOutput("depwb_op", 32'(rr_op), 32'd1);
    applySide(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h208, 6'd4, 8'd0, 4'd0, 4'd0, 4'd0, 1, 1, 32'd0);
    stepCycle("r0src");
    checkOutput("r0src_op", 32'(rr_op), 32'd4);
`endif

    // Asynchronous reset mid-stream
    applySide(0, 0, 0, 0, 0, 0, 0, 1, 4'd1, 32'h99);
    applyStimulus(1, 32'h300, 6'd6, 8'h7, 4'd0, 4'd0, 4'd0, 0, 0, 32'h42);
    stepCycle("prereset");
    #2;
    i_reset_n = 1'b0;
    #1;
    mReset();
    checkAll("asyncreset");
    checkOutput("asyncreset_ready", 32'(rr_ready), 32'd0);
    @(posedge i_clk);
    #1;
    checkAll("inreset");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    applySide(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h304, 6'd2, 8'd0, 4'd0, 4'd1, 4'd0, 1, 0, 32'd0);
    stepCycle("postreset");
    checkOutput("postreset_r1", rr_rs_val, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(3, 0) != 0), $urandom, 6'($urandom), 8'($urandom),
                    4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                    $urandom);
      applySide(($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0), 4'($urandom),
                $urandom, ($urandom_range(3, 0) == 0), 4'($urandom), $urandom,
                1'($urandom), 4'($urandom), $urandom);
      stepCycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
